// File: rtl/wb_burst_reader_if.sv
// Wishbone classic/burst read bus between the reader (master) and a responder.
interface wb_burst_reader_if;
    logic [23:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_we;
    logic [31:0] wb_dat_i;
    logic        wb_ack;

    modport master (
        output wb_adr, wb_sel, wb_cti, wb_stb, wb_cyc, wb_we,
        input  wb_dat_i, wb_ack
    );

    modport slave (
        input  wb_adr, wb_sel, wb_cti, wb_stb, wb_cyc, wb_we,
        output wb_dat_i, wb_ack
    );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone 4-beat incrementing burst reader feeding a FWFT FIFO.
// Defining WBR_TIMEOUT_EN adds a per-ack timeout that aborts the transfer.
module wb_burst_reader #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                        wb_clk,
    input  logic                        wb_rst,
    input  logic                        start,
    input  logic [23:0]                 base_adr,
    input  logic [11:0]                 len_bursts,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    wb_burst_reader_if.master           wb,
    input  logic                        rd_en,
    output logic [31:0]                 rd_data,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, GAP} state_t;

    state_t        r_state, w_next;
    logic [23:0]   r_adr;
    logic [11:0]   r_rem;
    logic [1:0]    r_beat;
    logic          r_done;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_level;

    logic w_start, w_ack, w_last, w_pop, w_space, w_tmo;

    assign w_start = (r_state == IDLE) && start;
    assign w_ack   = (r_state == BURST) && wb.wb_ack;
    assign w_last  = w_ack && (r_beat == 2'd3);
    assign w_pop   = rd_en && (r_level != '0);
    assign w_space = r_level <= (AW+1)'(FIFO_DEPTH - 4);

    always_ff @(posedge wb_clk) begin
        if (wb_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:       if (start && len_bursts != '0) w_next = WAIT_SPACE;
            WAIT_SPACE: if (w_space) w_next = BURST;
            BURST: begin
                if (w_last)     w_next = (r_rem == 12'd1) ? IDLE : GAP;
                else if (w_tmo) w_next = IDLE;
            end
            GAP:        w_next = WAIT_SPACE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_adr  <= '0;
            r_rem  <= '0;
            r_beat <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                if (len_bursts == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_adr  <= base_adr & 24'hFFFFFC;
                    r_rem  <= len_bursts;
                    r_beat <= '0;
                end
            end
            if (w_ack) begin
                r_adr  <= r_adr + 24'd4;
                r_beat <= r_beat + 2'd1;
            end
            if (w_last) begin
                r_rem <= r_rem - 12'd1;
                if (r_rem == 12'd1) r_done <= 1'b1;
            end
            if (w_tmo) r_done <= 1'b1;
        end
    end

`ifdef WBR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmo;
    logic          r_err;

    // Counter equals the number of ack-less BURST cycles already elapsed.
    assign w_tmo = (r_state == BURST) && !wb.wb_ack
                 && (r_tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != BURST || w_ack) r_tmo <= '0;
            else                           r_tmo <= r_tmo + 1'b1;
            if (w_start)    r_err <= 1'b0;
            else if (w_tmo) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge wb_clk) begin
        if (w_ack) r_mem[r_wp] <= wb.wb_dat_i;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_ack) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (w_ack && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_ack && w_pop) r_level <= r_level - 1'b1;
        end
    end

    assign busy       = r_state != IDLE;
    assign done       = r_done;
    assign rd_data    = r_mem[r_rp];
    assign fifo_empty = r_level == '0;
    assign fifo_level = r_level;

    assign wb.wb_cyc = r_state == BURST;
    assign wb.wb_stb = r_state == BURST;
    assign wb.wb_we  = 1'b0;
    assign wb.wb_sel = (r_state == BURST) ? 4'hF : 4'h0;
    assign wb.wb_adr = r_adr;
    assign wb.wb_cti = (r_state != BURST) ? 3'b000 :
                       (r_beat == 2'd3)   ? 3'b111 : 3'b010;
endmodule
